// File: rtl/muldiv_seq.sv
// Sequencer and HI/LO owner for the shared multi-cycle multiplier/divider in EX.
// Optional: define MUL_DIV_DIV0_FAST_EN to finish zero-divisor divides without the divider.
module muldiv_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_pipe_stall,
    input  logic        i_flush,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_hilo_wdata,
    output logic        o_busy,
    output logic [31:0] o_md_a,
    output logic [31:0] o_md_b,
    output logic        o_mul_start,
    output logic        o_mul_sign,
    input  logic        i_mul_ready,
    input  logic [63:0] i_mul_result,
    output logic        o_div_start,
    output logic        o_div_sign,
    output logic        o_div_annul,
    input  logic        i_div_ready,
    input  logic [63:0] i_div_result,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [2:0] {StIdle, StMulWait, StDivWait, StAcc, StDone} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic [2:0]  r_op;
    logic [63:0] r_p, w_p_d, w_acc;
    logic        w_issue, w_is_div, w_div0, w_latch, w_commit;

    assign w_issue  = i_op_valid && !i_flush;
    assign w_is_div = (i_op[2:1] == 2'b01);

`ifdef MUL_DIV_DIV0_FAST_EN
    assign w_div0 = w_is_div && (i_src_b == 32'd0);
`else
    assign w_div0 = 1'b0;
`endif

    // op[1] separates MSUB/MSUBU from MADD/MADDU
    assign w_acc = r_op[1] ? ({r_hi, r_lo} - r_p) : ({r_hi, r_lo} + r_p);

    always_comb begin
        w_state_d   = r_state;
        w_p_d       = r_p;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        o_busy      = 1'b0;
        o_mul_start = 1'b0;
        o_mul_sign  = 1'b0;
        o_div_start = 1'b0;
        o_div_sign  = 1'b0;
        o_div_annul = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    o_busy  = 1'b1;
                    w_latch = 1'b1;
                    if (w_div0) begin
                        w_state_d = StDone;
                        w_p_d     = {i_src_a, 32'hFFFF_FFFF};
                    end else if (w_is_div) begin
                        w_state_d = StDivWait;
                    end else begin
                        w_state_d = StMulWait;
                    end
                end
            end
            StMulWait: begin
                o_busy      = 1'b1;
                o_mul_start = 1'b1;
                o_mul_sign  = ~r_op[0];
                if (i_flush) begin
                    w_state_d = StIdle;
                end else if (i_mul_ready) begin
                    w_p_d     = i_mul_result;
                    w_state_d = r_op[2] ? StAcc : StDone;
                end
            end
            StDivWait: begin
                o_busy      = 1'b1;
                o_div_start = 1'b1;
                o_div_sign  = ~r_op[0];
                if (i_flush) begin
                    o_div_annul = 1'b1;
                    w_state_d   = StIdle;
                end else if (i_div_ready) begin
                    w_p_d     = i_div_result;
                    w_state_d = StDone;
                end
            end
            StAcc: begin
                o_busy = 1'b1;
                if (i_flush) begin
                    w_state_d = StIdle;
                end else begin
                    w_p_d     = w_acc;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                // op_valid is ignored here so a held instruction is never re-issued
                if (i_flush) begin
                    w_state_d = StIdle;
                end else if (!i_pipe_stall) begin
                    w_commit  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_p     <= 64'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_d;
            r_p     <= w_p_d;
            if (w_latch) begin
                r_a  <= i_src_a;
                r_b  <= i_src_b;
                r_op <= i_op;
            end
            // A commit wins over a same-cycle MTHI/MTLO
            if (w_commit) begin
                r_hi <= r_p[63:32];
            end else if (i_hi_we) begin
                r_hi <= i_hilo_wdata;
            end
            if (w_commit) begin
                r_lo <= r_p[31:0];
            end else if (i_lo_we) begin
                r_lo <= i_hilo_wdata;
            end
        end
    end

    assign o_md_a = r_a;
    assign o_md_b = r_b;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with behavioural 4-cycle multiplier and 5-cycle divider.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, op_valid, pipe_stall, flush, hi_we, lo_we;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, hilo_wdata;
    logic        busy, mul_start, mul_sign, mul_ready, div_start, div_sign, div_annul, div_ready;
    logic [31:0] md_a, md_b, hi, lo;
    logic [63:0] mul_result, div_result;

    int n_checks = 0;
    int n_pass   = 0;
    int mul_starts = 0;
    int div_starts = 0;
    int annuls     = 0;
    int mul_cnt    = 0;
    int div_cnt    = 0;

    muldiv_seq dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_op_valid   (op_valid),
        .i_op         (op),
        .i_src_a      (src_a),
        .i_src_b      (src_b),
        .i_pipe_stall (pipe_stall),
        .i_flush      (flush),
        .i_hi_we      (hi_we),
        .i_lo_we      (lo_we),
        .i_hilo_wdata (hilo_wdata),
        .o_busy       (busy),
        .o_md_a       (md_a),
        .o_md_b       (md_b),
        .o_mul_start  (mul_start),
        .o_mul_sign   (mul_sign),
        .i_mul_ready  (mul_ready),
        .i_mul_result (mul_result),
        .o_div_start  (div_start),
        .o_div_sign   (div_sign),
        .o_div_annul  (div_annul),
        .i_div_ready  (div_ready),
        .i_div_result (div_result),
        .o_hi         (hi),
        .o_lo         (lo)
    );

    always #5 clk = ~clk;

    // Unit models: ready in the 4th (mul) / 5th (div) cycle of start
    assign mul_ready = mul_start && (mul_cnt == 3);
    assign div_ready = div_start && (div_cnt == 4);

    always @(posedge clk) begin
        mul_cnt <= (!mul_start || mul_ready) ? 0 : mul_cnt + 1;
        div_cnt <= (!div_start || div_ready) ? 0 : div_cnt + 1;
    end

    always_comb begin
        if (mul_sign) mul_result = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
        else          mul_result = {32'd0, md_a} * {32'd0, md_b};
    end

    always_comb begin
        div_result = 64'd0;
        if (md_b == 32'd0)  div_result = {md_a, 32'hFFFF_FFFF};
        else if (div_sign)  div_result = {$signed(md_a) % $signed(md_b),
                                          $signed(md_a) / $signed(md_b)};
        else                div_result = {md_a % md_b, md_a / md_b};
    end

    always @(negedge clk) begin
        if (mul_start) mul_starts++;
        if (div_start) div_starts++;
        if (div_annul) annuls++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          exp_busy, exp_mst, exp_dst;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        hi_we = 1'b1; hilo_wdata = h; tick();
        hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = l; tick();
        lo_we = 1'b0;
    endtask

    // Counts cycles while busy; on return the DUT sits in DONE
    task automatic wait_not_busy(input string name, inout int n);
        int guard = 0;
        while (busy && guard < 100) begin
            n++; guard++; tick();
        end
        if (guard >= 100) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n);
        busy_n = 0;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        if (busy) busy_n++;
        tick();
        op_valid = 1'b0;
        wait_not_busy("run_op", busy_n);
        tick();
    endtask

    initial begin
        int bn, ms0, ds0, an0;
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        pipe_stall = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = 32'd0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 4, 0};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFE, 5, 4, 0};
        vecs[2] = '{3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 6, 0, 5};
        vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 6, 0, 5};
        vecs[4] = '{3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 6, 4, 0};
        vecs[5] = '{3'd4, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 32'd0, 32'd4, 6, 4, 0};
        vecs[6] = '{3'd7, 32'd2, 32'd3, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 4, 0};
        vecs[7] = '{3'd6, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'd0, 32'd6, 6, 4, 0};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'h4000_0000, 32'd0, 5, 4, 0};
        vecs[9] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'd1, 5, 4, 0};

        tick(); tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_starts", {62'd0, mul_start, div_start}, 64'd0);
        check("rst_signs_annul", {61'd0, mul_sign, div_sign, div_annul}, 64'd0);
        check("rst_md", {md_a, md_b}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            ms0 = mul_starts; ds0 = div_starts;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bn);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            check($sformatf("vec%0d_busy", i), 64'(bn), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_mstart", i), 64'(mul_starts - ms0), 64'(vecs[i].exp_mst));
            check($sformatf("vec%0d_dstart", i), 64'(div_starts - ds0), 64'(vecs[i].exp_dst));
        end

        // DIV held in DONE by pipe_stall with the instruction still presented
        preset(32'h11, 32'h22);
        ds0 = div_starts; bn = 0;
        op_valid = 1'b1; op = 3'd2; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        tick();
        wait_not_busy("hold", bn);
        pipe_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_busy", c), {63'd0, busy}, 64'd0);
            check($sformatf("hold%0d_hilo", c), {hi, lo}, {32'h11, 32'h22});
            tick();
        end
        pipe_stall = 1'b0;
        tick();
        op_valid = 1'b0;
        #1;
        check("hold_commit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tick();
        check("hold_no_reissue", 64'(div_starts - ds0), 64'd5);
        check("hold_idle", {62'd0, busy, div_start}, 64'd0);

        // Flush in the third DIV_WAIT cycle
        preset(32'hAA, 32'hBB);
        an0 = annuls;
        op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        #1;
        check("flush_annul", {63'd0, div_annul}, 64'd1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", {61'd0, busy, div_start, div_annul}, 64'd0);
        for (int c = 0; c < 6; c++) tick();
        check("flush_annul_once", 64'(annuls - an0), 64'd1);
        check("flush_hilo", {hi, lo}, {32'hAA, 32'hBB});
        run_op(3'd1, 32'd5, 32'd6, bn);
        check("after_flush_multu", {hi, lo}, {32'd0, 32'd30});

        // MTLO in the commit cycle loses; MTLO alone next cycle wins
        bn = 0;
        op_valid = 1'b1; op = 3'd1; src_a = 32'd2; src_b = 32'd3;
        tick();
        op_valid = 1'b0;
        wait_not_busy("mtlo", bn);
        lo_we = 1'b1; hilo_wdata = 32'h1234;
        tick();
        check("mtlo_vs_commit", {32'd0, lo}, 64'd6);
        tick();
        lo_we = 1'b0;
        #1;
        check("mtlo_alone", {32'd0, lo}, 64'h1234);

        // Divide by zero
        ds0 = div_starts;
`ifdef MUL_DIV_DIV0_FAST_EN
        op_valid = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd0;
        #1;
        check("div0_busy_c0", {63'd0, busy}, 64'd1);
        tick();
        op_valid = 1'b0;
        #1;
        check("div0_busy_c1", {63'd0, busy}, 64'd0);
        tick();
        check("div0_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        check("div0_no_start", 64'(div_starts - ds0), 64'd0);
`else
        run_op(3'd3, 32'd9, 32'd0, bn);
        check("div0_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        check("div0_busy", 64'(bn), 64'd6);
        check("div0_starts", 64'(div_starts - ds0), 64'd5);
`endif

        // Reset in the middle of a multiply
        op_valid = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        tick();
        op_valid = 1'b0;
        tick();
        check("pre_rst_start", {63'd0, mul_start}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_idle", {62'd0, busy, mul_start}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
